// File: rtl/ifm_prefetch.sv
// Prefetching fetch unit: pipelined Wishbone B4 reads into a PC-tagged FIFO, decode takes words via valid/ready.
// An ack in cycle N is visible in N+1; issue pauses while FIFO slots or the outstanding budget are used up.
module ifm_prefetch #(
  parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR      = 32'h0000_0010,
  parameter logic [31:0] DEBUG_VECTOR    = 32'h0000_0800,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          BOFFSET_WIDTH   = 20
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     irq_i,
  input  logic                     drq_i,
  input  logic                     branch_i,
  input  logic [BOFFSET_WIDTH-1:0] boffset_i,
  output logic [31:0]              wb_adr_o,
  input  logic [31:0]              wb_dat_i,
  output logic                     wb_we_o,
  output logic [3:0]               wb_sel_o,
  output logic                     wb_stb_o,
  input  logic                     wb_ack_i,
  output logic                     wb_cyc_o,
  input  logic                     wb_stall_i,
  output logic [31:0]              instr_o,
  output logic [31:0]              pc_o,
  input  logic                     output_ready_i,
  output logic                     output_valid_o
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Two spare bits so count + outstanding can be summed without overflow.
  localparam int CW = AW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTANDING);

  logic [31:0]   fetch_pc, last_pc;
  logic          stb;
  logic [CW-1:0] count, outstanding, discard;
  logic [AW-1:0] rd_ptr, wr_ptr, pq_rd, pq_wr;
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [31:0]   pc_queue   [FIFO_DEPTH];

  logic          empty, accept, ack_vld, keep, drop, pop, redirect, stb_nx;
  logic [31:0]   head_pc, base_pc, boff_ext, target, fetch_pc_nx;
  logic [CW-1:0] count_nx, outstanding_nx, discard_nx;

  assign empty    = (count == '0);
  assign accept   = stb & ~wb_stall_i;
  // Acks with nothing in flight (e.g. late ones after reset) are ignored.
  assign ack_vld  = wb_ack_i & ((outstanding != '0) | (discard != '0));
  assign keep     = ack_vld & (discard == '0);
  assign drop     = ack_vld & (discard != '0);
  assign pop      = ~empty & output_ready_i;
  assign redirect = drq_i | irq_i | branch_i;
  assign head_pc  = fifo_pc[rd_ptr];
  assign base_pc  = pop ? head_pc : last_pc;
  assign boff_ext = {{(31-BOFFSET_WIDTH){boffset_i[BOFFSET_WIDTH-1]}}, boffset_i, 1'b0};

  always_comb begin
    if (drq_i)      target = DEBUG_VECTOR;
    else if (irq_i) target = IRQ_VECTOR;
    else            target = base_pc + boff_ext;
  end

  always_comb begin
    count_nx       = count;
    outstanding_nx = outstanding;
    discard_nx     = discard;
    fetch_pc_nx    = fetch_pc;
    if (redirect) begin
      // Everything still in flight, including a request accepted this cycle, becomes a discard.
      count_nx       = '0;
      outstanding_nx = '0;
      discard_nx     = discard + outstanding + CW'(accept) - CW'(ack_vld);
      fetch_pc_nx    = target;
    end else begin
      count_nx       = count + CW'(keep) - CW'(pop);
      outstanding_nx = outstanding + CW'(accept) - CW'(keep);
      discard_nx     = discard - CW'(drop);
      fetch_pc_nx    = accept ? fetch_pc + 32'd4 : fetch_pc;
    end
    if (stb & wb_stall_i & ~redirect)
      stb_nx = 1'b1;
    else
      stb_nx = (discard_nx == '0) && (outstanding_nx < MAXO_C) &&
               ((count_nx + outstanding_nx) < DEPTH_C);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc    <= RESET_VECTOR;
      last_pc     <= RESET_VECTOR;
      stb         <= 1'b0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pq_rd       <= '0;
      pq_wr       <= '0;
    end else begin
      fetch_pc    <= fetch_pc_nx;
      stb         <= stb_nx;
      count       <= count_nx;
      outstanding <= outstanding_nx;
      discard     <= discard_nx;
      if (pop) last_pc <= head_pc;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        pq_rd  <= '0;
        pq_wr  <= '0;
      end else begin
        if (keep) begin
          wr_ptr <= wr_ptr + AW'(1);
          pq_rd  <= pq_rd + AW'(1);
        end
        if (pop)    rd_ptr <= rd_ptr + AW'(1);
        if (accept) pq_wr  <= pq_wr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (keep && !redirect) begin
      fifo_instr[wr_ptr] <= wb_dat_i;
      fifo_pc[wr_ptr]    <= pc_queue[pq_rd];
    end
    if (accept && !redirect) pc_queue[pq_wr] <= fetch_pc;
  end

  assign output_valid_o = ~empty;
  assign instr_o        = empty ? 32'h0 : fifo_instr[rd_ptr];
  assign pc_o           = empty ? 32'h0 : head_pc;
  assign wb_stb_o       = stb;
  assign wb_adr_o       = stb ? fetch_pc : 32'h0;
  assign wb_cyc_o       = stb | (outstanding != '0) | (discard != '0);
  assign wb_we_o        = 1'b0;
  assign wb_sel_o       = 4'hF;
endmodule

// File: tb/tb_ifm_prefetch.sv
// Directed bench for ifm_prefetch: a Wishbone slave model plus a scoreboard of expected {pc, instr} words.
module tb_ifm_prefetch;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] IRQ_VECTOR   = 32'h0000_0010;
  localparam logic [31:0] DEBUG_VECTOR = 32'h0000_0800;
  localparam int          MAX_OUT      = 2;

  logic        clk_i = 1'b0;
  logic        rst_i, irq_i, drq_i, branch_i;
  logic [19:0] boffset_i;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_ack_i = 1'b0;
  logic        wb_cyc_o;
  logic        wb_stall_i;
  logic [31:0] instr_o, pc_o;
  logic        output_ready_i, output_valid_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] sq[$];
  int          checks = 0;
  int          errors = 0;
  logic        ack_en = 1'b0;
  logic [31:0] exp_adr = RESET_VECTOR;
  logic [31:0] tb_last_pc = RESET_VECTOR;

  ifm_prefetch #(
    .RESET_VECTOR(RESET_VECTOR), .IRQ_VECTOR(IRQ_VECTOR), .DEBUG_VECTOR(DEBUG_VECTOR),
    .FIFO_DEPTH(4), .MAX_OUTSTANDING(MAX_OUT), .BOFFSET_WIDTH(20)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .irq_i(irq_i), .drq_i(drq_i), .branch_i(branch_i),
    .boffset_i(boffset_i), .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_cyc_o(wb_cyc_o),
    .wb_stall_i(wb_stall_i), .instr_o(instr_o), .pc_o(pc_o),
    .output_ready_i(output_ready_i), .output_valid_o(output_valid_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_stb(input string tag, input logic [31:0] adr);
    int n = 0;
    while (!wb_stb_o && n < 20) begin
      step(1);
      n++;
    end
    chk({tag, "_stb"}, 32'(wb_stb_o), 32'd1);
    chk(tag, wb_adr_o, adr);
  endtask

  task automatic wait_vld(input string tag, input logic [31:0] pc);
    int n = 0;
    while (!output_valid_o && n < 20) begin
      step(1);
      n++;
    end
    chk({tag, "_vld"}, 32'(output_valid_o), 32'd1);
    chk(tag, pc_o, pc);
  endtask

  // Slave: acks accepted requests in order, one cycle after acceptance, while ack_en is set.
  always @(posedge clk_i) begin
    #2;
    if (ack_en && sq.size() != 0) begin
      wb_ack_i = 1'b1;
      wb_dat_i = mem_word(sq.pop_front());
    end else begin
      wb_ack_i = 1'b0;
      wb_dat_i = 32'h0;
    end
  end

  // Observes each upcoming edge: accepted requests feed the scoreboard, pops are checked, redirects flush.
  always @(negedge clk_i) begin : monitor
    logic [31:0] base, tgt;
    exp_t        e;
    if (!rst_i) begin
      exp_q.delete();
      exp_adr    = RESET_VECTOR;
      tb_last_pc = RESET_VECTOR;
    end else begin
      if (wb_stb_o && !wb_stall_i) begin
        chk("req_adr", wb_adr_o, exp_adr);
        exp_q.push_back('{pc: exp_adr, ins: mem_word(exp_adr)});
        sq.push_back(wb_adr_o);
        exp_adr = exp_adr + 32'd4;
        chk("outstanding_max", 32'(sq.size() <= MAX_OUT), 32'd1);
      end
      base = tb_last_pc;
      if (output_valid_o && output_ready_i) begin
        chk("pop_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_pc", pc_o, e.pc);
          chk("out_instr", instr_o, e.ins);
          base       = e.pc;
          tb_last_pc = e.pc;
        end
      end
      if (drq_i || irq_i || branch_i) begin
        if (drq_i)      tgt = DEBUG_VECTOR;
        else if (irq_i) tgt = IRQ_VECTOR;
        else            tgt = base + {{11{boffset_i[19]}}, boffset_i, 1'b0};
        exp_q.delete();
        exp_adr = tgt;
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base, stall_adr;
    rst_i = 1'b0; irq_i = 1'b0; drq_i = 1'b0; branch_i = 1'b0; boffset_i = 20'h0;
    wb_stall_i = 1'b0; output_ready_i = 1'b0; ack_en = 1'b1;
    step(2);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_valid", 32'(output_valid_o), 32'd0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("we_const", 32'(wb_we_o), 32'd0);
    chk("sel_const", 32'(wb_sel_o), 32'hF);

    // Fill with decode stalled: four words buffered, then issue stops.
    rst_i = 1'b1;
    step(1);
    chk("first_stb", 32'(wb_stb_o), 32'd1);
    chk("first_adr", wb_adr_o, RESET_VECTOR);
    step(1);
    chk("valid_before_ack", 32'(output_valid_o), 32'd0);
    step(1);
    chk("first_valid", 32'(output_valid_o), 32'd1);
    chk("first_pc", pc_o, 32'h0);
    chk("first_instr", instr_o, mem_word(32'h0));
    step(4);
    chk("full_valid", 32'(output_valid_o), 32'd1);
    chk("full_stb", 32'(wb_stb_o), 32'd0);
    chk("full_cyc", 32'(wb_cyc_o), 32'd0);
    chk("full_count", 32'(exp_q.size()), 32'd4);
    step(2);
    chk("hold_pc", pc_o, 32'h0);
    chk("hold_instr", instr_o, mem_word(32'h0));

    // Drain and stream; fetch resumes at 0x10.
    output_ready_i = 1'b1;
    step(12);

    // Three stalled cycles on one request.
    wait_stb("pre_stall", exp_adr);
    stall_adr  = wb_adr_o;
    wb_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("stall_adr", wb_adr_o, stall_adr);
      chk("stall_stb", 32'(wb_stb_o), 32'd1);
    end
    wb_stall_i = 1'b0;
    step(6);

    // Branch +16 bytes from the popped PC with two requests in flight.
    output_ready_i = 1'b0;
    ack_en = 1'b0;
    step(5);
    chk("pre_br_valid", 32'(output_valid_o), 32'd1);
    chk("pre_br_inflight", 32'(sq.size()), 32'd2);
    chk("pre_br_stb", 32'(wb_stb_o), 32'd0);
    base = pc_o;
    output_ready_i = 1'b1;
    branch_i = 1'b1;
    boffset_i = 20'h00008;
    step(1);
    branch_i = 1'b0;
    output_ready_i = 1'b0;
    ack_en = 1'b1;
    chk("br_flush_valid", 32'(output_valid_o), 32'd0);
    chk("br_stb", 32'(wb_stb_o), 32'd0);
    chk("br_cyc", 32'(wb_cyc_o), 32'd1);
    wait_stb("br_target", base + 32'h10);
    output_ready_i = 1'b1;
    wait_vld("br_first_pc", base + 32'h10);
    step(6);

    // All three redirects at once: debug wins.
    drq_i = 1'b1; irq_i = 1'b1; branch_i = 1'b1; boffset_i = 20'h00008;
    step(1);
    drq_i = 1'b0; irq_i = 1'b0; branch_i = 1'b0;
    chk("dbg_flush_valid", 32'(output_valid_o), 32'd0);
    wait_stb("dbg_target", DEBUG_VECTOR);
    step(6);

    // Reset with requests outstanding and words buffered.
    output_ready_i = 1'b0;
    ack_en = 1'b0;
    step(5);
    chk("rst2_pre_valid", 32'(output_valid_o), 32'd1);
    chk("rst2_pre_inflight", 32'(sq.size()), 32'd2);
    rst_i = 1'b0;
    #1;
    chk("rst2_stb", 32'(wb_stb_o), 32'd0);
    chk("rst2_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst2_adr", wb_adr_o, 32'h0);
    chk("rst2_valid", 32'(output_valid_o), 32'd0);
    chk("rst2_pc", pc_o, 32'h0);
    chk("rst2_instr", instr_o, 32'h0);
    wb_stall_i = 1'b1;
    step(2);
    rst_i = 1'b1;
    ack_en = 1'b1;
    step(3);
    chk("stray_valid", 32'(output_valid_o), 32'd0);
    chk("stray_drained", 32'(sq.size()), 32'd0);
    chk("restart_stb", 32'(wb_stb_o), 32'd1);
    chk("restart_adr", wb_adr_o, RESET_VECTOR);

    // Negative branch from pc 0 while the first request is stalled, then wrap to 0.
    branch_i = 1'b1;
    boffset_i = 20'hFFFFE;
    step(1);
    branch_i = 1'b0;
    chk("neg_stb", 32'(wb_stb_o), 32'd1);
    chk("neg_adr", wb_adr_o, 32'hFFFF_FFFC);
    wb_stall_i = 1'b0;
    step(6);
    chk("wrap_valid", 32'(output_valid_o), 32'd1);
    chk("wrap_head_pc", pc_o, 32'hFFFF_FFFC);
    output_ready_i = 1'b1;
    step(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
